// File: rtl/rs_codeword_framer.sv
// Frames an upstream symbol stream into n-symbol Reed-Solomon codewords with start/end markers.
// Optional macro RS_FRAMER_PAD_EN: short messages are zero-filled to n symbols instead of ending early.
module rs_codeword_framer #(
    parameter int unsigned word_length = 8,
    parameter int unsigned n           = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [word_length-1:0] i_symbol,
    input  logic                   i_last,
    output logic                   o_in_ready,
    input  logic                   i_out_ready,
    output logic                   o_valid,
    output logic                   o_start_codeword,
    output logic                   o_end_codeword,
    output logic [word_length-1:0] o_symbol,
    output logic [15:0]            o_cw_count
);

    localparam int unsigned POS_W = (n > 2) ? $clog2(n) : 1;
    localparam int unsigned CNT_W = 16;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(n - 1);

`ifdef RS_FRAMER_PAD_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;
`endif

    state_t                 state_q, state_d;
    logic [POS_W-1:0]       pos_q, pos_d;
    logic                   valid_q, valid_d;
    logic [word_length-1:0] sym_q, sym_d;
    logic                   start_q, start_d;
    logic                   end_q, end_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic out_free;
    logic in_xfer;
    logic at_last_pos;

    // Output register is free when empty or being drained this cycle.
    assign out_free    = !valid_q || i_out_ready;
    assign at_last_pos = (pos_q == LAST_POS);

`ifdef RS_FRAMER_PAD_EN
    assign o_in_ready = out_free && (state_q != PAD) && !rst;
`else
    assign o_in_ready = out_free && !rst;
`endif

    assign in_xfer = i_valid && o_in_ready;

    // State, position, output stage and codeword counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pos_q   <= '0;
            valid_q <= 1'b0;
            sym_q   <= '0;
            start_q <= 1'b0;
            end_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            valid_q <= valid_d;
            sym_q   <= sym_d;
            start_q <= start_d;
            end_q   <= end_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, framing and output-stage logic.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        valid_d = valid_q;
        sym_d   = sym_q;
        start_d = start_q;
        end_d   = end_q;
        cnt_d   = cnt_q;

        if (valid_q && i_out_ready) begin
            valid_d = 1'b0;
            if (end_q) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            IDLE, DATA: begin
                if (in_xfer) begin
                    valid_d = 1'b1;
                    sym_d   = i_symbol;
                    start_d = (pos_q == '0);
`ifdef RS_FRAMER_PAD_EN
                    if (at_last_pos) begin
                        end_d   = 1'b1;
                        pos_d   = '0;
                        state_d = IDLE;
                    end else begin
                        end_d   = 1'b0;
                        pos_d   = pos_q + POS_W'(1);
                        state_d = i_last ? PAD : DATA;
                    end
`else
                    if (at_last_pos || i_last) begin
                        end_d   = 1'b1;
                        pos_d   = '0;
                        state_d = IDLE;
                    end else begin
                        end_d   = 1'b0;
                        pos_d   = pos_q + POS_W'(1);
                        state_d = DATA;
                    end
`endif
                end
            end
`ifdef RS_FRAMER_PAD_EN
            PAD: begin
                // Zero-fill the remainder of a short message.
                if (out_free) begin
                    valid_d = 1'b1;
                    sym_d   = '0;
                    start_d = 1'b0;
                    end_d   = at_last_pos;
                    if (at_last_pos) begin
                        pos_d   = '0;
                        state_d = IDLE;
                    end else begin
                        pos_d   = pos_q + POS_W'(1);
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
                pos_d   = '0;
            end
        endcase
    end

    assign o_valid          = valid_q;
    assign o_symbol         = sym_q;
    assign o_start_codeword = start_q;
    assign o_end_codeword   = end_q;
    assign o_cw_count       = cnt_q;

endmodule

// File: tb/tb_rs_codeword_framer.sv
// Scoreboard bench for rs_codeword_framer (n=15, 8-bit symbols); directed vectors, hand-computed expectations.
module tb_rs_codeword_framer;

    localparam int unsigned WL = 8;
    localparam int unsigned N  = 15;

    logic          clk;
    logic          rst;
    logic          i_valid;
    logic [WL-1:0] i_symbol;
    logic          i_last;
    logic          o_in_ready;
    logic          i_out_ready;
    logic          o_valid;
    logic          o_start_codeword;
    logic          o_end_codeword;
    logic [WL-1:0] o_symbol;
    logic [15:0]   o_cw_count;

    typedef struct {
        logic [WL-1:0] sym;
        logic          sop;
        logic          eop;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    rs_codeword_framer #(.word_length(WL), .n(N)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_valid          (i_valid),
        .i_symbol         (i_symbol),
        .i_last           (i_last),
        .o_in_ready       (o_in_ready),
        .i_out_ready      (i_out_ready),
        .o_valid          (o_valid),
        .o_start_codeword (o_start_codeword),
        .o_end_codeword   (o_end_codeword),
        .o_symbol         (o_symbol),
        .o_cw_count       (o_cw_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [WL-1:0] s, input logic sop, input logic eop);
        exp_t e;
        e.sym = s;
        e.sop = sop;
        e.eop = eop;
        exp_q.push_back(e);
    endtask

    // Offer one symbol and hold it until the framer accepts it.
    task automatic send(input logic [WL-1:0] s, input logic last);
        bit got;
        got      = 1'b0;
        i_valid  = 1'b1;
        i_symbol = s;
        i_last   = last;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (o_in_ready === 1'b1) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=no_ready required=ready sym=0x%0h", s);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    // Wait until every expected output has been transferred downstream.
    task automatic drain();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 200 && !done; t++) begin
            @(posedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        #1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
        end
    endtask

    // Monitor: compare each downstream transfer against the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b0 && o_valid === 1'b1 && i_out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output actual=0x%0h required=none", o_symbol);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_symbol", 32'(o_symbol), 32'(e.sym));
                chk("out_start", 32'(o_start_codeword), 32'(e.sop));
                chk("out_end", 32'(o_end_codeword), 32'(e.eop));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        i_valid     = 1'b0;
        i_symbol    = '0;
        i_last      = 1'b0;
        i_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_symbol", 32'(o_symbol), 32'd0);
        chk("reset_markers", 32'({o_start_codeword, o_end_codeword}), 32'd0);
        chk("reset_count", 32'(o_cw_count), 32'd0);
        chk("reset_in_ready", 32'(o_in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 32'(o_in_ready), 32'd1);

        // Full codeword 0x01..0x0F.
        for (int i = 1; i <= 15; i++) push(WL'(i), i == 1, i == 15);
        for (int i = 1; i <= 15; i++) send(WL'(i), 1'b0);
        drain();
        chk("count_after_full", 32'(o_cw_count), 32'd1);

        // Short message of 4 symbols.
`ifdef RS_FRAMER_PAD_EN
        for (int i = 1; i <= 4; i++) push(WL'(8'h40 + i), i == 1, 1'b0);
        for (int i = 5; i <= 15; i++) push('0, 1'b0, i == 15);
        for (int i = 1; i <= 4; i++) send(WL'(8'h40 + i), i == 4);
        begin
            int lows;
            lows = 0;
            for (int t = 0; t < 40; t++) begin
                @(negedge clk);
                if (o_in_ready === 1'b1) break;
                lows++;
            end
            chk("pad_ready_low_cycles", 32'(lows), 32'd11);
        end
`else
        for (int i = 1; i <= 4; i++) push(WL'(8'h40 + i), i == 1, i == 4);
        for (int i = 1; i <= 4; i++) send(WL'(8'h40 + i), i == 4);
`endif
        drain();
        chk("count_after_short", 32'(o_cw_count), 32'd2);

        // Single-symbol message.
`ifdef RS_FRAMER_PAD_EN
        push(8'h99, 1'b1, 1'b0);
        for (int i = 2; i <= 15; i++) push('0, 1'b0, i == 15);
`else
        push(8'h99, 1'b1, 1'b1);
`endif
        send(8'h99, 1'b1);
        drain();
        chk("count_after_single", 32'(o_cw_count), 32'd3);

        // Downstream stall of 5 cycles mid-codeword.
        for (int i = 1; i <= 15; i++) push(WL'(8'h20 + i), i == 1, i == 15);
        fork
            begin
                for (int i = 1; i <= 15; i++) send(WL'(8'h20 + i), 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                i_out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(o_valid), 32'd1);
                    chk("stall_in_ready", 32'(o_in_ready), 32'd0);
                    if (exp_q.size() > 0) begin
                        chk("stall_symbol", 32'(o_symbol), 32'(exp_q[0].sym));
                        chk("stall_markers", 32'({o_start_codeword, o_end_codeword}),
                            32'({exp_q[0].sop, exp_q[0].eop}));
                    end
                end
                @(posedge clk);
                #1;
                i_out_ready = 1'b1;
            end
        join
        drain();
        chk("count_after_stall", 32'(o_cw_count), 32'd4);

        // Reset after 7 symbols (pos=7): partial codeword discarded, no end marker.
        for (int i = 1; i <= 7; i++) push(WL'(8'h60 + i), i == 1, 1'b0);
        for (int i = 1; i <= 7; i++) send(WL'(8'h60 + i), 1'b0);
        @(posedge clk);
        #1;
        chk("prereset_drained", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", 32'(o_in_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_count", 32'(o_cw_count), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        rst = 1'b0;
        for (int i = 1; i <= 15; i++) push(WL'(8'h70 + i), i == 1, i == 15);
        for (int i = 1; i <= 15; i++) send(WL'(8'h70 + i), 1'b0);
        drain();
        chk("count_after_reset_cw", 32'(o_cw_count), 32'd1);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
